// File: rtl/line_buffer_3.sv
// line_buffer_3: two-row line buffer producing vertical 3-pixel columns from a
// raster pixel stream. Optional top-border replication is enabled by defining
// LINE_BUF_EDGE_REPLICATE_EN (default build: rows 0 and 1 produce no output).
module line_buffer_3 #(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int unsigned WIDTH      = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_clr,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3
);

    localparam int unsigned CW    = 11;
    localparam int unsigned DEPTH = int'(PIC_WIDTH);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // l1_mem holds the previous row, l2_mem the row before it
    logic [WIDTH-1:0] l1_mem [DEPTH];
    logic [WIDTH-1:0] l2_mem [DEPTH];

    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [CW-1:0]    col_cur, row_cur;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] l1_rd, l2_rd;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dout1_q, dout1_d;
    logic [WIDTH-1:0] dout2_q, dout2_d;
    logic [WIDTH-1:0] dout3_q, dout3_d;

    // Effective position: frame_clr makes the current pixel row 0, col 0
    always_comb begin
        col_cur = frame_clr ? '0 : col_q;
        row_cur = frame_clr ? '0 : row_q;
        rd_idx  = AW'(col_cur);
        l1_rd   = l1_mem[rd_idx];
        l2_rd   = l2_mem[rd_idx];
    end

    // Next-state for position counters and registered outputs
    always_comb begin
        col_d   = col_cur;
        row_d   = row_cur;
        valid_d = 1'b0;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        dout3_d = dout3_q;
        if (valid_in) begin
            if (col_cur == PIC_WIDTH - 11'd1) begin
                col_d = '0;
                row_d = (row_cur == PIC_HEIGHT - 11'd1) ? '0 : row_cur + 11'd1;
            end else begin
                col_d = col_cur + 11'd1;
            end
            dout3_d = din;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
            valid_d = 1'b1;
            if (row_cur == 11'd0) begin
                dout1_d = din;
                dout2_d = din;
            end else if (row_cur == 11'd1) begin
                dout1_d = l1_rd;
                dout2_d = l1_rd;
            end else begin
                dout1_d = l2_rd;
                dout2_d = l1_rd;
            end
`else
            valid_d = (row_cur >= 11'd2);
            dout1_d = l2_rd;
            dout2_d = l1_rd;
`endif
        end
    end

    // Line memories shift one row down on every accepted pixel; never reset
    always_ff @(posedge clk) begin
        if (valid_in) begin
            l1_mem[rd_idx] <= din;
            l2_mem[rd_idx] <= l1_rd;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            dout1_q <= '0;
            dout2_q <= '0;
            dout3_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            dout3_q <= dout3_d;
        end
    end

    assign valid_out = valid_q;
    assign dout1     = dout1_q;
    assign dout2     = dout2_q;
    assign dout3     = dout3_q;

endmodule

// File: tb/tb_line_buffer_3.sv
// Testbench for line_buffer_3 on a 4x4 picture, checked against a frame-image
// reference model (expected column triples taken from a 2-D image array).
module tb_line_buffer_3;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_clr;
    logic        valid_in;
    logic [23:0] din;
    logic        valid_out;
    logic [23:0] dout1, dout2, dout3;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state
    logic [23:0] img [H][W];
    int          idx;
    logic        exp_v;
    logic        exp_known;
    logic [23:0] exp1, exp2, exp3;

    line_buffer_3 #(.PIC_WIDTH(11'd4), .PIC_HEIGHT(11'd4), .WIDTH(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_clr (frame_clr),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3)
    );

    always #5 clk = ~clk;

    // drive one cycle and advance the model; returns #1 after the rising edge
    task automatic drive(input logic v, input logic [23:0] d, input logic fc);
        int r, c;
        @(negedge clk);
        valid_in  = v;
        din       = d;
        frame_clr = fc;
        if (fc) idx = 0;
        if (v) begin
            r = idx / W;
            c = idx % W;
            exp3 = d;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
            exp_v = 1'b1;
            exp_known = 1'b1;
            if (r == 0) begin exp1 = d; exp2 = d; end
            else if (r == 1) begin exp1 = img[0][c]; exp2 = img[0][c]; end
            else begin exp1 = img[r-2][c]; exp2 = img[r-1][c]; end
`else
            exp_v = (r >= 2);
            exp_known = exp_v;
            if (r >= 2) begin exp1 = img[r-2][c]; exp2 = img[r-1][c]; end
`endif
            img[r][c] = d;
            idx = (idx + 1) % (W * H);
        end else begin
            exp_v = 1'b0;
        end
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        frame_clr = 1'b0;
    endtask

    task automatic model_reset();
        idx = 0; exp_v = 1'b0; exp_known = 1'b1;
        exp1 = '0; exp2 = '0; exp3 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; frame_clr = 1'b0; din = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b exp 0", valid_out); end
        tests_run++;
        if (dout1 !== 24'h0) begin tests_failed++; $display("FAIL reset_dout1: got %h exp 0", dout1); end
        tests_run++;
        if (dout2 !== 24'h0) begin tests_failed++; $display("FAIL reset_dout2: got %h exp 0", dout2); end
        tests_run++;
        if (dout3 !== 24'h0) begin tests_failed++; $display("FAIL reset_dout3: got %h exp 0", dout3); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // counting stream 1..16, continuous; name selects the message tag
    task automatic test_stream(input string name);
        int pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 24'(i), 1'b0);
            tests_run++;
            if (valid_out !== exp_v || (exp_known && {dout1, dout2, dout3} !== {exp1, exp2, exp3})) begin
                tests_failed++;
                $display("FAIL %s px%0d: got v=%0b %h %h %h exp v=%0b %h %h %h", name, i,
                         valid_out, dout1, dout2, dout3, exp_v, exp1, exp2, exp3);
            end
            if (valid_out === 1'b1) pulses++;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
            if (i == 2 || i == 6) begin
                tests_run++;
                if ({dout1, dout2, dout3} !== {24'h2, 24'h2, 24'(i)}) begin
                    tests_failed++;
                    $display("FAIL %s_edge px%0d: got %h %h %h", name, i, dout1, dout2, dout3);
                end
            end
`else
            if (i == 9) begin
                tests_run++;
                if ({valid_out, dout1, dout2, dout3} !== {1'b1, 24'h1, 24'h5, 24'h9}) begin
                    tests_failed++;
                    $display("FAIL %s_first: got v=%0b %h %h %h exp 1 000001 000005 000009",
                             name, valid_out, dout1, dout2, dout3);
                end
            end
`endif
        end
        tests_run++;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
        if (pulses != 16) begin tests_failed++; $display("FAIL %s_count: got %0d exp 16", name, pulses); end
`else
        if (pulses != 8) begin tests_failed++; $display("FAIL %s_count: got %0d exp 8", name, pulses); end
`endif
    endtask

    task automatic test_gapped();
        int pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            for (int g = 0; g < 2; g++) begin
                drive(g == 0, 24'(i), 1'b0);
                tests_run++;
                if (valid_out !== exp_v || (exp_known && {dout1, dout2, dout3} !== {exp1, exp2, exp3})) begin
                    tests_failed++;
                    $display("FAIL gapped px%0d g%0d: got v=%0b %h %h %h exp v=%0b %h %h %h", i, g,
                             valid_out, dout1, dout2, dout3, exp_v, exp1, exp2, exp3);
                end
                if (valid_out === 1'b1) pulses++;
            end
        end
        tests_run++;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
        if (pulses != 16) begin tests_failed++; $display("FAIL gapped_count: got %0d exp 16", pulses); end
`else
        if (pulses != 8) begin tests_failed++; $display("FAIL gapped_count: got %0d exp 8", pulses); end
`endif
    endtask

    // frame_clr with a pixel at row 2, col 1, then finish the restarted frame
    task automatic test_frame_clr();
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 24'($urandom), i == 9);
            tests_run++;
            if (valid_out !== exp_v || (exp_known && {dout1, dout2, dout3} !== {exp1, exp2, exp3})) begin
                tests_failed++;
                $display("FAIL frame_clr px%0d: got v=%0b %h %h %h exp v=%0b %h %h %h", i,
                         valid_out, dout1, dout2, dout3, exp_v, exp1, exp2, exp3);
            end
`ifndef LINE_BUF_EDGE_REPLICATE_EN
            if (i == 9) begin
                tests_run++;
                if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL frame_clr_mask: got %0b exp 0", valid_out); end
            end
`endif
        end
    endtask

    // async reset at row 3, col 2 then a full counting frame
    task automatic test_async_reset();
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 24'($urandom_range(1, 24'hFFFFFF)), 1'b0);
            tests_run++;
            if (valid_out !== exp_v || (exp_known && {dout1, dout2, dout3} !== {exp1, exp2, exp3})) begin
                tests_failed++;
                $display("FAIL pre_reset px%0d: got v=%0b %h %h %h exp v=%0b %h %h %h", i,
                         valid_out, dout1, dout2, dout3, exp_v, exp1, exp2, exp3);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({valid_out, dout1, dout2, dout3} !== 73'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%0b %h %h %h exp all 0", valid_out, dout1, dout2, dout3);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_stream("post_reset");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 24'((i % 16) + 1), 1'b0);
            tests_run++;
            if (valid_out !== exp_v || (exp_known && {dout1, dout2, dout3} !== {exp1, exp2, exp3})) begin
                tests_failed++;
                $display("FAIL b2b px%0d: got v=%0b %h %h %h exp v=%0b %h %h %h", i,
                         valid_out, dout1, dout2, dout3, exp_v, exp1, exp2, exp3);
            end
            if (valid_out === 1'b1) begin
                pulses++;
`ifndef LINE_BUF_EDGE_REPLICATE_EN
                if (pulses == 9) begin
                    tests_run++;
                    if ({dout1, dout2, dout3} !== {24'h1, 24'h5, 24'h9}) begin
                        tests_failed++;
                        $display("FAIL b2b_frame2_first: got %h %h %h exp 000001 000005 000009", dout1, dout2, dout3);
                    end
                end
`endif
            end
        end
        tests_run++;
`ifdef LINE_BUF_EDGE_REPLICATE_EN
        if (pulses != 32) begin tests_failed++; $display("FAIL b2b_count: got %0d exp 32", pulses); end
`else
        if (pulses != 16) begin tests_failed++; $display("FAIL b2b_count: got %0d exp 16", pulses); end
`endif
    endtask

    task automatic test_random();
        logic v, fc;
        for (int i = 0; i < 300; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            fc = ($urandom_range(0, 40) == 0);
            drive(v, 24'($urandom), fc);
            tests_run++;
            if (valid_out !== exp_v || (exp_known && {dout1, dout2, dout3} !== {exp1, exp2, exp3})) begin
                tests_failed++;
                $display("FAIL random cyc%0d: got v=%0b %h %h %h exp v=%0b %h %h %h", i,
                         valid_out, dout1, dout2, dout3, exp_v, exp1, exp2, exp3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream("stream");
        test_gapped();
        test_frame_clr();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/line_buffer_3.md
LINE_BUFFER_3 -- requirements
Module: line_buffer_3

Interface
REQ-001 SHALL have parameter PIC_WIDTH, default 11'd250: pixels per image row.
REQ-002 SHALL have parameter PIC_HEIGHT, default 11'd250: rows per frame.
REQ-003 SHALL have parameter WIDTH, default 24: pixel width, packed {R[23:16],G[15:8],B[7:0]}.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port frame_clr  input  1: synchronous, one-cycle pulse that restarts the frame.
REQ-007 SHALL have port valid_in  input  1: din carries a pixel this cycle.
REQ-008 SHALL have port din  input  WIDTH: raster-order pixel stream.
REQ-009 SHALL have port valid_out  output  1: dout1..dout3 hold a new vertical triple this cycle.
REQ-010 SHALL have port dout1  output  WIDTH: pixel from row r-2 (top), same column.
REQ-011 SHALL have port dout2  output  WIDTH: pixel from row r-1 (middle), same column.
REQ-012 SHALL have port dout3  output  WIDTH: current pixel, row r (bottom).

Function
REQ-013 SHALL hold two line memories of PIC_WIDTH x WIDTH: L1 (previous row) and L2 (row before it), with combinational read.
REQ-014 SHALL keep column counter col (0..PIC_WIDTH-1) and row counter row (0..PIC_HEIGHT-1), each 11 bits.
REQ-015 SHALL, on valid_in=1: read L1[col] and L2[col], write L1[col]<=din and L2[col]<=old L1[col], in the same cycle.
REQ-016 SHALL register dout3<=din, dout2<=old L1[col], dout1<=old L2[col]; latency is exactly 1 clk from valid_in to valid_out.
REQ-017 SHALL advance col on every valid_in; at col=PIC_WIDTH-1, col wraps to 0 and row increments.
REQ-018 SHALL wrap row from PIC_HEIGHT-1 to 0 on the last pixel of the frame; the next pixel is treated as row 0.
REQ-019 SHALL, when valid_in=0: hold col, row, memories and dout1..dout3, and drive valid_out=0; gaps inside a row are allowed.
REQ-020 SHALL, on frame_clr=1: set col=0 and row=0; if valid_in is also 1, process that pixel as row 0, col 0 and advance to col=1.
REQ-021 SHALL drive valid_out=1 only for pixels whose row >= 2 (without REQ-029); valid_out is a one-cycle pulse per accepted pixel.
REQ-022 SHALL NOT clear memory contents on frame wrap or on frame_clr; stale data is masked by REQ-021 or REQ-029.

Reset
REQ-023 SHALL, while rst_n=0, force col=0, row=0, valid_out=0, dout1=dout2=dout3=0, regardless of clk.
REQ-024 SHALL NOT require memory contents to be reset.
REQ-025 SHALL, on reset mid-row, discard the partial row; the first pixel after release is row 0, col 0.

Configuration
REQ-026 SHALL use the macro LINE_BUF_EDGE_REPLICATE_EN.
REQ-027 SHALL, without the macro, behave exactly as REQ-021: rows 0 and 1 produce no valid_out, so output row count = PIC_HEIGHT-2.
REQ-028 SHALL, with the macro, assert valid_out for every accepted pixel, so output row count = PIC_HEIGHT.
REQ-029 SHALL, with the macro, replicate the top border as follows:
- row 0: dout1=dout2=dout3=din.
- row 1: dout1=dout2=old L1[col] (row 0 pixel), dout3=din.
- row >= 2: per REQ-016.

Verification
REQ-030 SHALL, with PIC_WIDTH=4, PIC_HEIGHT=4, no macro, and din=0x000001..0x000010 streamed continuously, produce:
- no valid_out for the first 8 pixels;
- then 8 valid_out pulses;
- first triple dout1=0x000001, dout2=0x000005, dout3=0x000009, one clk after pixel 0x000009.
REQ-031 SHALL, with the same stream but valid_in toggling 1/0 every cycle, produce the identical triple sequence, with valid_out only on cycles following valid_in=1.
REQ-032 SHALL, with the macro and the same stream, produce:
- 16 valid_out pulses;
- pixel 0x000002 gives triple (0x000002, 0x000002, 0x000002);
- pixel 0x000006 gives (0x000002, 0x000002, 0x000006).
REQ-033 SHALL, when frame_clr and valid_in are asserted together mid-frame at row 2, col 1, treat that pixel as row 0: no valid_out without the macro, and col=1 next cycle.
REQ-034 SHALL, when rst_n is asserted low at row 3, col 2, clear all outputs to 0 asynchronously; after release, a full 4x4 frame reproduces REQ-030 exactly.
REQ-035 SHALL, across two back-to-back frames (32 pixels, no macro), produce exactly 16 valid_out pulses, with frame-2 first triple (0x000001, 0x000005, 0x000009).
